// File: rtl/input_pkg.sv
// Package for the input debounce bank.
// Holds the default counter widths shared by the bank top level and the per-lane module.
package input_pkg;

  // At 100 MHz: 2^18 cycles is about 2.6 ms of stable level before it is accepted.
  localparam int unsigned DEBOUNCE_CNT_W = 18;
  // 2^26 cycles is about 0.67 s of press before a long-press strobe.
  localparam int unsigned HOLD_CNT_W     = 26;
  // 2^24 cycles is about 168 ms between auto-repeat strobes.
  localparam int unsigned REPEAT_CNT_W   = 24;

endpackage

// File: rtl/input_debounce_bank_if.sv
// Bus between the raw button pads and the input decoder.
//   in   : raw asynchronous inputs, 1 = pressed (driven by master)
//   out  : debounced level
//   ondn : one-cycle strobe on press
//   onup : one-cycle strobe on release
//   hold : one-cycle strobe when a press reaches the long-press threshold
//   rpt  : one-cycle auto-repeat strobe (0 when repeat is compiled out)
// The debouncer connects through the slave modport. The pad side and the
// consumer of the strobes connect through the master modport.
interface input_debounce_bank_if #(
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] ondn;
  logic [CHANNELS-1:0] onup;
  logic [CHANNELS-1:0] hold;
  logic [CHANNELS-1:0] rpt;

  modport master (
    output in,
    input  out, ondn, onup, hold, rpt
  );

  modport slave (
    input  in,
    output out, ondn, onup, hold, rpt
  );
endinterface

// File: rtl/input_debounce_lane.sv
// One debounce lane. It contains a 2-flop synchroniser, the debounce counter,
// a saturating long-press counter and an optional auto-repeat counter.
// Macro INPUT_DEBOUNCE_REPEAT_EN builds the repeat counter. When the macro is
// undefined, rpt_o is 0.
// Ports: clk, rst (async, active-high), in_i (raw input), out_o (debounced level),
//        ondn_o/onup_o (press/release strobes), hold_o (long-press strobe),
//        rpt_o (auto-repeat strobe).
module input_debounce_lane
  import input_pkg::*;
#(
  parameter int unsigned CNT_W    = DEBOUNCE_CNT_W,
  parameter int unsigned HOLD_W   = HOLD_CNT_W,
  parameter int unsigned REPEAT_W = REPEAT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o,
  output logic ondn_o,
  output logic onup_o,
  output logic hold_o,
  output logic rpt_o
);

  if (CNT_W < 1 || HOLD_W < 1 || REPEAT_W < 1) begin : g_param_check
    $error("input_debounce_lane: counter widths must be at least 1");
  end

  logic [1:0]        sync_q, sync_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              out_q, out_d;
  logic              held_q, held_d;
  logic              ondn_q, ondn_d;
  logic              onup_q, onup_d;
  logic              hold_q, hold_d;
  logic              s;

  assign s = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], in_i};
    cnt_d      = '0;
    out_d      = out_q;
    ondn_d     = 1'b0;
    onup_d     = 1'b0;
    hold_cnt_d = hold_cnt_q;
    held_d     = held_q;
    hold_d     = 1'b0;

    // Any cycle of agreement clears the count, so a glitch restarts the count.
    if (s != out_q) begin
      if (&cnt_q) begin
        out_d  = s;
        ondn_d = s;
        onup_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (!out_q) begin
      hold_cnt_d = '0;
      held_d     = 1'b0;
    end else begin
      if (!(&hold_cnt_q)) hold_cnt_d = hold_cnt_q + 1'b1;
      // Gating on out_d stops hold from firing in the same cycle as onup.
      if (out_d && (&hold_cnt_q) && !held_q) begin
        hold_d = 1'b1;
        held_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      out_q      <= 1'b0;
      held_q     <= 1'b0;
      ondn_q     <= 1'b0;
      onup_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
      out_q      <= out_d;
      held_q     <= held_d;
      ondn_q     <= ondn_d;
      onup_q     <= onup_d;
      hold_q     <= hold_d;
    end
  end

`ifdef INPUT_DEBOUNCE_REPEAT_EN
  logic [REPEAT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic                rpt_q, rpt_d;

  // The counter starts the cycle after hold fires. It wraps freely, so rpt
  // repeats every 2^REPEAT_W cycles.
  always_comb begin
    rep_cnt_d = '0;
    rpt_d     = hold_d;
    if (out_q && held_q) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
      if (out_d && (&rep_cnt_q)) rpt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

  assign out_o  = out_q;
  assign ondn_o = ondn_q;
  assign onup_o = onup_q;
  assign hold_o = hold_q;

endmodule

// File: rtl/input_debounce_bank.sv
// Multi-channel push-button and switch debouncer. The module creates one
// independent input_debounce_lane per channel. Each lane gives a debounced
// level, press and release strobes, a long-press strobe and an optional
// auto-repeat strobe.
// Macro INPUT_DEBOUNCE_REPEAT_EN builds the auto-repeat logic. When the macro
// is undefined, rpt is constant 0.
// Ports: clk, rst (async, active-high), bus (input_debounce_bank_if.slave:
//        in -> out/ondn/onup/hold/rpt, CHANNELS bits each).
module input_debounce_bank
  import input_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CNT_W    = DEBOUNCE_CNT_W,
  parameter int unsigned HOLD_W   = HOLD_CNT_W,
  parameter int unsigned REPEAT_W = REPEAT_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  input_debounce_bank_if.slave bus
);

  logic [CHANNELS-1:0] out_vec;
  logic [CHANNELS-1:0] ondn_vec;
  logic [CHANNELS-1:0] onup_vec;
  logic [CHANNELS-1:0] hold_vec;
  logic [CHANNELS-1:0] rpt_vec;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    input_debounce_lane #(
      .CNT_W    (CNT_W),
      .HOLD_W   (HOLD_W),
      .REPEAT_W (REPEAT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .in_i   (bus.in[i]),
      .out_o  (out_vec[i]),
      .ondn_o (ondn_vec[i]),
      .onup_o (onup_vec[i]),
      .hold_o (hold_vec[i]),
      .rpt_o  (rpt_vec[i])
    );
  end

  assign bus.out  = out_vec;
  assign bus.ondn = ondn_vec;
  assign bus.onup = onup_vec;
  assign bus.hold = hold_vec;
  assign bus.rpt  = rpt_vec;

endmodule
